// File: rtl/uart_dna_rx.sv
// UART receiver (4x oversampling, optional parity) feeding a byte-to-packet
// assembler that rebuilds the peer's 64-bit device-DNA code word.
module uart_dna_rx #(
    parameter int PKT_BYTES      = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst_h,
    input  logic        i_en_h,
    input  logic [15:0] i_div,
    input  logic        i_parity_en_h,
    input  logic        i_parity_type_el_oh,
    input  logic        i_rx,
    output logic [7:0]  o_byte,
    output logic        o_byte_vld_h,
    output logic [63:0] o_code,
    output logic        o_code_vld_h,
    output logic        o_frame_err_h,
    output logic        o_parity_err_h,
    output logic        o_busy_h
);

    localparam int CW = $clog2(PKT_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_reg, state_next;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] div_eff, div_cnt;
    logic [1:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  data_sh;
    logic        par_err_reg;
    logic        tick, falling, mid_start, bit_end;
    logic        start_go, take_data, take_par, stop_ok, stop_ferr, stop_perr;

    assign div_eff   = (i_div == 16'd0) ? 16'd1 : i_div;
    assign tick      = (state_reg != S_IDLE) && (div_cnt == div_eff - 16'd1);
    assign falling   = rx_prev & ~rx_sync;
    assign mid_start = tick && (tick_cnt == 2'd1);
    assign bit_end   = tick && (tick_cnt == 2'd3);
    assign o_busy_h  = (state_reg != S_IDLE);

    always_comb begin
        state_next = state_reg;
        start_go   = 1'b0;
        take_data  = 1'b0;
        take_par   = 1'b0;
        stop_ok    = 1'b0;
        stop_ferr  = 1'b0;
        stop_perr  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (falling) begin
                    start_go   = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (mid_start) begin
                    state_next = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    take_data = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = i_parity_en_h ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    take_par   = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!rx_sync) begin
                        stop_ferr  = 1'b1;
                        state_next = S_BREAK;
                    end else if (par_err_reg) begin
                        stop_perr  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_ok    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (!i_en_h) begin
            state_next = S_IDLE;
            start_go   = 1'b0;
            take_data  = 1'b0;
            take_par   = 1'b0;
            stop_ok    = 1'b0;
            stop_ferr  = 1'b0;
            stop_perr  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_h) begin
        if (i_rst_h) begin
            rx_meta        <= 1'b1;
            rx_sync        <= 1'b1;
            rx_prev        <= 1'b1;
            state_reg      <= S_IDLE;
            div_cnt        <= 16'd0;
            tick_cnt       <= 2'd0;
            bit_cnt        <= 3'd0;
            data_sh        <= 8'd0;
            par_err_reg    <= 1'b0;
            o_byte         <= 8'd0;
            o_byte_vld_h   <= 1'b0;
            o_frame_err_h  <= 1'b0;
            o_parity_err_h <= 1'b0;
        end else begin
            rx_meta   <= i_rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state_reg <= state_next;

            if (!i_en_h || state_reg == S_IDLE || tick) begin
                div_cnt <= 16'd0;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end

            // Realign the tick phase at mid start bit so data bits sample at their centres
            if (state_reg == S_IDLE || (state_reg == S_START && mid_start)) begin
                tick_cnt <= 2'd0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 2'd1;
            end

            if (start_go) begin
                bit_cnt     <= 3'd0;
                par_err_reg <= 1'b0;
            end
            if (take_data) begin
                data_sh <= {rx_sync, data_sh[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (take_par) begin
                par_err_reg <= ((^data_sh) ^ rx_sync) != i_parity_type_el_oh;
            end

            o_byte_vld_h   <= stop_ok;
            o_frame_err_h  <= stop_ferr;
            o_parity_err_h <= stop_perr;
            if (stop_ok) begin
                o_byte <= data_sh;
            end
        end
    end

    logic [CW-1:0] byte_cnt, byte_cnt_next;
    logic [TW-1:0] idle_cnt;
    logic [63:0]   shadow;
    logic          to_expire;

    // A byte arriving on the expiry cycle starts a fresh packet
    assign to_expire     = (byte_cnt != '0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign byte_cnt_next = to_expire ? CW'(1) : byte_cnt + CW'(1);

    always_ff @(posedge i_clk or posedge i_rst_h) begin
        if (i_rst_h) begin
            byte_cnt     <= '0;
            idle_cnt     <= '0;
            shadow       <= 64'd0;
            o_code       <= 64'd0;
            o_code_vld_h <= 1'b0;
        end else begin
            o_code_vld_h <= 1'b0;
            if (!i_en_h || o_frame_err_h || o_parity_err_h) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (o_byte_vld_h) begin
                shadow   <= {shadow[55:0], o_byte};
                idle_cnt <= '0;
                if (byte_cnt_next == CW'(PKT_BYTES)) begin
                    o_code       <= {shadow[55:0], o_byte};
                    o_code_vld_h <= 1'b1;
                    byte_cnt     <= '0;
                end else begin
                    byte_cnt <= byte_cnt_next;
                end
            end else if (to_expire) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (byte_cnt != '0) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_dna_rx.sv
// Bench for uart_dna_rx: drives serial frames and compares captured strobes,
// bytes and code words against a byte/packet-level reference model.
module tb_uart_dna_rx;
    localparam int TO = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [15:0] div = 16'd108;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  o_byte;
    logic        o_byte_vld;
    logic [63:0] o_code;
    logic        o_code_vld;
    logic        o_ferr;
    logic        o_perr;
    logic        o_busy;

    always #5 clk = ~clk;

    uart_dna_rx #(.PKT_BYTES(8), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk),
        .i_rst_h(rst),
        .i_en_h(en),
        .i_div(div),
        .i_parity_en_h(par_en),
        .i_parity_type_el_oh(par_odd),
        .i_rx(rx),
        .o_byte(o_byte),
        .o_byte_vld_h(o_byte_vld),
        .o_code(o_code),
        .o_code_vld_h(o_code_vld),
        .o_frame_err_h(o_ferr),
        .o_parity_err_h(o_perr),
        .o_busy_h(o_busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Observed activity
    logic [7:0]  got_bytes[$];
    longint      got_cyc[$];
    logic [63:0] got_codes[$];
    int          n_ferr = 0;
    int          n_perr = 0;
    int          n_misalign = 0;
    logic        prev_bv = 1'b0;
    longint      cyc = 0;

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_bv <= o_byte_vld;
        if (!rst) begin
            if (o_byte_vld) begin
                got_bytes.push_back(o_byte);
                got_cyc.push_back(cyc);
            end
            if (o_code_vld) begin
                got_codes.push_back(o_code);
                if (!prev_bv) n_misalign <= n_misalign + 1;
            end
            if (o_ferr) n_ferr <= n_ferr + 1;
            if (o_perr) n_perr <= n_perr + 1;
        end
    end

    // Reference model: accepted bytes, completed packets, error counts
    logic [7:0]  m_bytes[$];
    logic [63:0] m_codes[$];
    logic [7:0]  m_pkt[$];
    int          m_ferr = 0;
    int          m_perr = 0;
    logic [63:0] m_code = 64'd0;

    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit stop_v);
        logic [63:0] c;
        if (!stop_v) begin
            m_ferr++;
            m_pkt.delete();
        end else if (par_en && bad_par) begin
            m_perr++;
            m_pkt.delete();
        end else begin
            m_bytes.push_back(b);
            m_pkt.push_back(b);
            if (m_pkt.size() == 8) begin
                c = 64'd0;
                for (int i = 0; i < 8; i++) c = c + (64'(m_pkt[i]) << (8 * (7 - i)));
                m_codes.push_back(c);
                m_code = c;
                m_pkt.delete();
            end
        end
    endtask

    task automatic hold_bits(input logic v, input int nbits);
        int d;
        d = (div == 16'd0) ? 1 : int'(div);
        rx = v;
        repeat (nbits * 4 * d) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit bad_par, input bit stop_v);
        hold_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) hold_bits(b[i], 1);
        if (par_en) hold_bits((^b) ^ par_odd ^ bad_par, 1);
        hold_bits(stop_v, 1);
        if (!stop_v) hold_bits(1'b1, 1);
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit stop_v);
        model_frame(b, bad_par, stop_v);
        drive_frame(b, bad_par, stop_v);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic flush();
        idle(TO + 100);
        m_pkt.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({o_byte, o_code} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_data: got byte=%h code=%h, expected 0", o_byte, o_code);
        end
        n_checks++;
        if ({o_byte_vld, o_code_vld, o_ferr, o_perr, o_busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {o_byte_vld, o_code_vld, o_ferr, o_perr, o_busy});
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_byte();
        int gb0, f0, p0;
        longint t0, lat;
        div = 16'd108;
        gb0 = got_bytes.size(); f0 = n_ferr; p0 = n_perr; t0 = cyc;
        send(8'hA5, 1'b0, 1'b1);
        idle(20);
        n_checks++;
        if (got_bytes.size() !== gb0 + 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d bytes expected 1", got_bytes.size() - gb0);
        end
        n_checks++;
        if (got_bytes[gb0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_value: got %h expected a5", got_bytes[gb0]);
        end
        lat = got_cyc[gb0] - t0;
        n_checks++;
        if (lat < 38 * 108 - 108 || lat > 38 * 108 + 116) begin
            n_fail++;
            $display("FAIL single_latency: got %0d clocks expected about %0d", lat, 38 * 108);
        end
        n_checks++;
        if ((n_ferr - f0) + (n_perr - p0) !== 0) begin
            n_fail++;
            $display("FAIL single_errors: got %0d error strobes expected 0", (n_ferr - f0) + (n_perr - p0));
        end
        flush();
        $display("test_single_byte: byte=%h latency=%0d", got_bytes[gb0], lat);
    endtask

    task automatic test_back_to_back();
        int gb0, gc0;
        div = 16'd4;
        gb0 = got_bytes.size(); gc0 = got_codes.size();
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (got_bytes.size() !== gb0 + 8) begin
            n_fail++;
            $display("FAIL b2b_bytes: got %0d expected 8", got_bytes.size() - gb0);
        end
        n_checks++;
        if (got_codes.size() !== gc0 + 1) begin
            n_fail++;
            $display("FAIL b2b_code_count: got %0d expected 1", got_codes.size() - gc0);
        end
        n_checks++;
        if (o_code !== 64'h0102030405060708) begin
            n_fail++;
            $display("FAIL b2b_code: got %h expected 0102030405060708", o_code);
        end
        n_checks++;
        if (n_misalign !== 0) begin
            n_fail++;
            $display("FAIL b2b_code_timing: got %0d misaligned code strobes expected 0", n_misalign);
        end
        $display("test_back_to_back: code=%h", o_code);
    endtask

    task automatic test_frame_error();
        int gb0, gc0, f0;
        gb0 = got_bytes.size(); gc0 = got_codes.size(); f0 = n_ferr;
        send(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (n_ferr - f0 !== 1) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0);
        end
        n_checks++;
        if (got_bytes.size() !== gb0 + 8) begin
            n_fail++;
            $display("FAIL ferr_bytes: got %0d expected 8", got_bytes.size() - gb0);
        end
        n_checks++;
        if (got_codes.size() !== gc0 + 1 || o_code !== m_code) begin
            n_fail++;
            $display("FAIL ferr_code: got %h (%0d strobes) expected %h", o_code, got_codes.size() - gc0, m_code);
        end
        $display("test_frame_error: code=%h", o_code);
    endtask

    task automatic test_parity();
        int gb0, p0, f0;
        gb0 = got_bytes.size(); p0 = n_perr; f0 = n_ferr;
        par_en = 1'b1; par_odd = 1'b1;
        send(8'h03, 1'b0, 1'b1);
        send(8'h03, 1'b1, 1'b1);
        idle(10);
        par_en = 1'b0; par_odd = 1'b0;
        n_checks++;
        if (got_bytes.size() !== gb0 + 1 || got_bytes[gb0] !== 8'h03) begin
            n_fail++;
            $display("FAIL parity_good: got %0d bytes first=%h expected 1 byte 03", got_bytes.size() - gb0, got_bytes[gb0]);
        end
        n_checks++;
        if (n_perr - p0 !== 1 || n_ferr - f0 !== 0) begin
            n_fail++;
            $display("FAIL parity_err: got perr=%0d ferr=%0d expected 1 0", n_perr - p0, n_ferr - f0);
        end
        $display("test_parity done");
    endtask

    task automatic test_glitch();
        int gb0, f0, p0;
        bit saw;
        gb0 = got_bytes.size(); f0 = n_ferr; p0 = n_perr; saw = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 4 * int'(div) + 4; i++) begin
            if (i == int'(div)) rx = 1'b1;
            @(negedge clk);
            if (o_busy) saw = 1'b1;
        end
        idle(20);
        n_checks++;
        if (saw !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_seen: got busy never set expected busy pulse");
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: got %b expected 0", o_busy);
        end
        n_checks++;
        if (got_bytes.size() !== gb0 || n_ferr !== f0 || n_perr !== p0) begin
            n_fail++;
            $display("FAIL glitch_strobes: got bytes=%0d ferr=%0d perr=%0d expected 0",
                     got_bytes.size() - gb0, n_ferr - f0, n_perr - p0);
        end
        $display("test_glitch done");
    endtask

    task automatic test_timeout();
        int gc0;
        gc0 = got_codes.size();
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        flush();
        for (int i = 1; i <= 8; i++) send(8'(i * 17), 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (got_codes.size() !== gc0 + 1 || o_code !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL timeout_code: got %h (%0d strobes) expected 1122334455667788", o_code, got_codes.size() - gc0);
        end
        $display("test_timeout: code=%h", o_code);
    endtask

    task automatic test_reset_mid_frame();
        int gb0, f0, p0;
        logic [7:0] b;
        gb0 = got_bytes.size(); f0 = n_ferr; p0 = n_perr;
        hold_bits(1'b0, 1);
        hold_bits(1'b1, 1);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_code !== 64'd0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got code=%h busy=%b expected 0 0", o_code, o_busy);
        end
        rst = 1'b0;
        m_pkt.delete();
        m_code = 64'd0;
        idle(40);
        b = 8'($urandom_range(0, 255));
        send(b, 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (got_bytes.size() !== gb0 + 1 || got_bytes[gb0] !== b || n_ferr !== f0 || n_perr !== p0) begin
            n_fail++;
            $display("FAIL midreset_next: got %0d bytes first=%h errs=%0d expected 1 byte %h",
                     got_bytes.size() - gb0, got_bytes[gb0], (n_ferr - f0) + (n_perr - p0), b);
        end
        flush();
        $display("test_reset_mid_frame: byte=%h", b);
    endtask

    task automatic test_enable();
        int gb0;
        logic [7:0] b;
        gb0 = got_bytes.size();
        en = 1'b0;
        m_pkt.delete();
        drive_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (got_bytes.size() !== gb0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled: got %0d bytes busy=%b expected 0 0", got_bytes.size() - gb0, o_busy);
        end
        en = 1'b1;
        idle(20);
        b = 8'($urandom_range(0, 255));
        send(b, 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (got_bytes.size() !== gb0 + 1 || got_bytes[gb0] !== b) begin
            n_fail++;
            $display("FAIL reenabled: got %0d bytes first=%h expected 1 byte %h", got_bytes.size() - gb0, got_bytes[gb0], b);
        end
        flush();
        $display("test_enable: byte=%h", b);
    endtask

    task automatic test_div_zero();
        int gb0;
        logic [7:0] b;
        gb0 = got_bytes.size();
        div = 16'd0;
        b = 8'($urandom_range(0, 255));
        send(b, 1'b0, 1'b1);
        idle(10);
        n_checks++;
        if (got_bytes.size() !== gb0 + 1 || got_bytes[gb0] !== b) begin
            n_fail++;
            $display("FAIL div_zero: got %0d bytes first=%h expected 1 byte %h", got_bytes.size() - gb0, got_bytes[gb0], b);
        end
        div = 16'd4;
        flush();
        $display("test_div_zero: byte=%h", b);
    endtask

    task automatic test_random();
        int gb0, gc0, mb0, mc0, f0, p0, mf0, mp0;
        gb0 = got_bytes.size(); gc0 = got_codes.size(); f0 = n_ferr; p0 = n_perr;
        mb0 = m_bytes.size(); mc0 = m_codes.size(); mf0 = m_ferr; mp0 = m_perr;
        for (int i = 0; i < 40; i++) begin
            par_en  = 1'($urandom_range(0, 1));
            par_odd = 1'($urandom_range(0, 1));
            send(8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0);
            idle($urandom_range(0, 150));
        end
        par_en = 1'b0;
        idle(10);
        n_checks++;
        if (got_bytes.size() - gb0 !== m_bytes.size() - mb0) begin
            n_fail++;
            $display("FAIL rand_byte_count: got %0d expected %0d", got_bytes.size() - gb0, m_bytes.size() - mb0);
        end else begin
            for (int i = 0; i < m_bytes.size() - mb0; i++) begin
                n_checks++;
                if (got_bytes[gb0 + i] !== m_bytes[mb0 + i]) begin
                    n_fail++;
                    $display("FAIL rand_byte[%0d]: got %h expected %h", i, got_bytes[gb0 + i], m_bytes[mb0 + i]);
                end
            end
        end
        n_checks++;
        if (got_codes.size() - gc0 !== m_codes.size() - mc0) begin
            n_fail++;
            $display("FAIL rand_code_count: got %0d expected %0d", got_codes.size() - gc0, m_codes.size() - mc0);
        end else begin
            for (int i = 0; i < m_codes.size() - mc0; i++) begin
                n_checks++;
                if (got_codes[gc0 + i] !== m_codes[mc0 + i]) begin
                    n_fail++;
                    $display("FAIL rand_code[%0d]: got %h expected %h", i, got_codes[gc0 + i], m_codes[mc0 + i]);
                end
            end
        end
        n_checks++;
        if (n_ferr - f0 !== m_ferr - mf0 || n_perr - p0 !== m_perr - mp0) begin
            n_fail++;
            $display("FAIL rand_errors: got ferr=%0d perr=%0d expected %0d %0d",
                     n_ferr - f0, n_perr - p0, m_ferr - mf0, m_perr - mp0);
        end
        $display("test_random: %0d bytes %0d codes", m_bytes.size() - mb0, m_codes.size() - mc0);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_frame_error();
        test_parity();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        test_enable();
        test_div_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
